// File: rtl/rnn_matvec.sv
// ---------------------------------------------------------------------------
// rnn_matvec
//
// Register-mapped matrix-vector engine: y[c] = (sum_r x[r] * W[r][c]) >>> FRAC_BITS.
// One MAC per clock while running. The row index r moves fastest and the
// column index c slowest. Each y[c] is committed on the cycle its last MAC
// completes.
//
// Write map (addr[2:0]):
//   0 control {data_in[0] = start}
//   1 vector  {idx[31:16], value[15:0]}
//   2 weight  {row[31:24], col[23:16], value[15:0]}
//   4 result select {data_in[7:0]}
// Read map (addr[2:0]):
//   0 status {30'b0, done, busy}
//   4 y[sel] sign-extended (0 when sel >= OUT_DIM)
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   read     register read strobe; data_out updates on the following edge
//   write    register write strobe; wins over a coincident read, and the read
//            returns the pre-write value
//   addr     register address; only addr[2:0] is decoded
//   data_in  write data
//   data_out registered read data, held while read is low
//
// Optional feature: define RNN_MATVEC_SAT_EN to saturate each shifted result
// to the DATA_W signed range. Without it, results wrap to the low DATA_W bits.
// ---------------------------------------------------------------------------
module rnn_matvec #(
    parameter int IN_DIM    = 2,
    parameter int OUT_DIM   = 4,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);
    localparam int ACC_W = 2 * DATA_W + 8;
    localparam int XI_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int YI_W  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [XI_W-1:0] ROW_LAST = XI_W'(IN_DIM - 1);
    localparam logic [YI_W-1:0] COL_LAST = YI_W'(OUT_DIM - 1);

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_VEC  = 3'd1;
    localparam logic [2:0] A_WGT  = 3'd2;
    localparam logic [2:0] A_SEL  = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [XI_W-1:0]          r_row;
    logic [YI_W-1:0]          r_col;
    logic signed [ACC_W-1:0]  r_acc;
    logic [7:0]               r_sel;
    logic [31:0]              r_data_out;
    logic signed [DATA_W-1:0] r_x [IN_DIM];
    logic signed [DATA_W-1:0] r_w [IN_DIM][OUT_DIM];
    logic signed [DATA_W-1:0] r_y [OUT_DIM];

    logic                     w_wr_vec;
    logic                     w_wr_wgt;
    logic                     w_wr_sel;
    logic                     w_start;
    logic                     w_vec_ok;
    logic                     w_wgt_ok;
    logic [XI_W-1:0]          w_vec_idx;
    logic [XI_W-1:0]          w_wgt_row;
    logic [YI_W-1:0]          w_wgt_col;
    logic signed [DATA_W-1:0] w_value;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DATA_W-1:0] w_y_next;
    logic [31:0]              w_rd_data;
    logic                     w_unused;

    assign w_wr_vec = write && (addr[2:0] == A_VEC);
    assign w_wr_wgt = write && (addr[2:0] == A_WGT);
    assign w_wr_sel = write && (addr[2:0] == A_SEL);
    assign w_start  = write && (addr[2:0] == A_CTRL) && data_in[0];

    // Range checks use the full index fields so that out-of-range indices
    // cannot alias onto a valid entry through the narrower array index.
    assign w_vec_ok  = ({16'd0, data_in[31:16]} < 32'(IN_DIM));
    assign w_wgt_ok  = ({24'd0, data_in[31:24]} < 32'(IN_DIM)) &&
                       ({24'd0, data_in[23:16]} < 32'(OUT_DIM));
    assign w_vec_idx = data_in[16 +: XI_W];
    assign w_wgt_row = data_in[24 +: XI_W];
    assign w_wgt_col = data_in[16 +: YI_W];
    assign w_value   = data_in[DATA_W-1:0];

    // The accumulator restarts with the first row of every column.
    assign w_prod     = ACC_W'(r_x[r_row]) * ACC_W'(r_w[r_row][r_col]);
    assign w_acc_next = (r_row == '0) ? w_prod : r_acc + w_prod;
    assign w_shift    = w_acc_next >>> FRAC_BITS;

`ifdef RNN_MATVEC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        w_y_next = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_y_next = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_y_next = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    assign w_y_next = w_shift[DATA_W-1:0];
`endif

    // NOTE: default assigned first so every path drives w_rd_data; no latch is inferred.
    always_comb begin
        w_rd_data = '0;
        case (addr[2:0])
            A_CTRL: w_rd_data = {30'd0, r_done, r_busy};
            A_SEL: begin
                if ({24'd0, r_sel} < 32'(OUT_DIM)) begin
                    w_rd_data = 32'(r_y[r_sel[YI_W-1:0]]);
                end
            end
            default: w_rd_data = '0;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is also what makes a coincident read return the pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_sel      <= '0;
            r_data_out <= '0;
            // NOTE: the x, W and y storage is cleared explicitly because reset must
            // leave every entry at zero; this is a register file, not a RAM macro.
            for (int r = 0; r < IN_DIM; r++) begin
                r_x[r] <= '0;
                for (int c = 0; c < OUT_DIM; c++) begin
                    r_w[r][c] <= '0;
                end
            end
            for (int c = 0; c < OUT_DIM; c++) begin
                r_y[c] <= '0;
            end
        end else begin
            if (read) begin
                r_data_out <= w_rd_data;
            end
            if (w_wr_sel) begin
                r_sel <= data_in[7:0];
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_wr_vec && w_vec_ok) begin
                        r_x[w_vec_idx] <= w_value;
                    end
                    if (w_wr_wgt && w_wgt_ok) begin
                        r_w[w_wgt_row][w_wgt_col] <= w_value;
                    end
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_row == ROW_LAST) begin
                        r_y[r_col] <= w_y_next;
                        r_row      <= '0;
                        if (r_col == COL_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_col <= r_col + YI_W'(1);
                        end
                    end else begin
                        r_row <= r_row + XI_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = r_data_out;

    // Address bits above [2:0] and value bits beyond DATA_W are intentionally ignored.
    assign w_unused = ^{addr[31:3], data_in};

endmodule

// File: tb/tb_rnn_matvec.sv
// ---------------------------------------------------------------------------
// tb_rnn_matvec
//
// Two instances share one register bus: u_dut (FRAC_BITS = 0) and u_dut_frac
// (FRAC_BITS = 2). Both must agree with a reference model that computes each
// result directly as a wide sum of products. The sum is then shifted, and
// either saturated or wrapped to 16 bits.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rnn_matvec;
    localparam int IN_DIM  = 2;
    localparam int OUT_DIM = 4;
    localparam int N_MAC   = IN_DIM * OUT_DIM;
    localparam int FRAC_B  = 2;

`ifdef RNN_MATVEC_SAT_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = 14464;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        read    = 1'b0;
    logic        write   = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] data_in = '0;
    logic [31:0] dout;
    logic [31:0] dout_f;

    int checks = 0;
    int errors = 0;

    int m_x [IN_DIM];
    int m_w [IN_DIM][OUT_DIM];

    rnn_matvec #(
        .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(16), .FRAC_BITS(0)
    ) u_dut (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(dout)
    );

    rnn_matvec #(
        .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .DATA_W(16), .FRAC_BITS(FRAC_B)
    ) u_dut_frac (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(dout_f)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int s16(input int v);
        logic [31:0]        u;
        logic signed [15:0] t;
        u = v;
        t = u[15:0];
        return int'(t);
    endfunction

    function automatic int model_y(input int c, input int frac);
        longint acc;
        acc = 0;
        for (int r = 0; r < IN_DIM; r++) begin
            acc += longint'(m_x[r]) * longint'(m_w[r][c]);
        end
        acc = acc >>> frac;
`ifdef RNN_MATVEC_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return int'(acc);
`else
        return s16(int'(acc));
`endif
    endfunction

    task automatic model_clear();
        for (int r = 0; r < IN_DIM; r++) begin
            m_x[r] = 0;
            for (int c = 0; c < OUT_DIM; c++) m_w[r][c] = 0;
        end
    endtask

    // ---------------- bus helpers (no comparisons) ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        write   = 1'b1;
        addr    = {29'd0, a};
        data_in = d;
        @(negedge clk);
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic [31:0] df);
        read = 1'b1;
        addr = {29'd0, a};
        @(negedge clk);
        read = 1'b0;
        addr = '0;
        d    = dout;
        df   = dout_f;
    endtask

    task automatic set_x(input int idx, input int val);
        logic [31:0] iv;
        logic [31:0] vv;
        iv = idx;
        vv = val;
        bus_write(3'd1, {iv[15:0], vv[15:0]});
        if (idx >= 0 && idx < IN_DIM) m_x[idx] = s16(val);
    endtask

    task automatic set_w(input int r, input int c, input int val);
        logic [31:0] rv;
        logic [31:0] cv;
        logic [31:0] vv;
        rv = r;
        cv = c;
        vv = val;
        bus_write(3'd2, {rv[7:0], cv[7:0], vv[15:0]});
        if (r >= 0 && r < IN_DIM && c >= 0 && c < OUT_DIM) m_w[r][c] = s16(val);
    endtask

    task automatic load_random(input bit do_x, input bit do_w);
        for (int r = 0; r < IN_DIM; r++) begin
            if (do_x) set_x(r, int'($urandom_range(0, 65535)));
            for (int c = 0; c < OUT_DIM; c++) begin
                if (do_w) set_w(r, c, int'($urandom_range(0, 65535)));
            end
        end
    endtask

    task automatic read_y(input int c, output logic [31:0] d, output logic [31:0] df);
        logic [31:0] cv;
        cv = c;
        bus_write(3'd4, {24'd0, cv[7:0]});
        bus_read(3'd4, d, df);
    endtask

    // Polls status once per cycle until it stops reading busy (bounded).
    task automatic run_measure(output int busy_cnt, output logic [31:0] fin, output logic [31:0] fin_f);
        logic [31:0] d;
        logic [31:0] df;
        bit          seen_end;
        seen_end = 1'b0;
        busy_cnt = 0;
        fin      = '0;
        fin_f    = '0;
        for (int i = 0; i < 64 && !seen_end; i++) begin
            bus_read(3'd0, d, df);
            if (d == 32'd1) begin
                busy_cnt++;
            end else begin
                seen_end = 1'b1;
                fin      = d;
                fin_f    = df;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] df;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (dout !== 32'd0 || dout_f !== 32'd0) begin
            errors++;
            $display("FAIL reset_data_out: got %h/%h, expected 0", dout, dout_f);
        end
        bus_read(3'd0, d, df);
        checks++;
        if (d !== 32'd0 || df !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got %h/%h, expected 0", d, df);
        end
        for (int c = 0; c < OUT_DIM; c++) begin
            read_y(c, d, df);
            checks++;
            if (d !== 32'd0 || df !== 32'd0) begin
                errors++;
                $display("FAIL reset_y%0d: got %h/%h, expected 0", c, d, df);
            end
        end
        bus_read(3'd1, d, df);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_unmapped_read: got %h, expected 0", d);
        end
    endtask

    task automatic test_directed();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        int          exp_y [OUT_DIM];
        exp_y = '{-14, -47, -56, 3};
        set_x(0, 2);
        set_x(1, -3);
        set_w(0, 0, 2);  set_w(0, 1, -10); set_w(0, 2, -10); set_w(0, 3, 3);
        set_w(1, 0, 6);  set_w(1, 1, 9);   set_w(1, 2, 12);  set_w(1, 3, 1);
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        checks++;
        if (busy !== N_MAC) begin
            errors++;
            $display("FAIL directed_latency: busy cycles %0d, expected %0d", busy, N_MAC);
        end
        checks++;
        if (st !== 32'd2 || stf !== 32'd2) begin
            errors++;
            $display("FAIL directed_done: status %h/%h, expected 2", st, stf);
        end
        for (int c = 0; c < OUT_DIM; c++) begin
            read_y(c, d, df);
            checks++;
            if (d !== 32'(exp_y[c])) begin
                errors++;
                $display("FAIL directed_y%0d: got %0d, expected %0d", c, $signed(d), exp_y[c]);
            end
            checks++;
            if (df !== 32'(model_y(c, FRAC_B))) begin
                errors++;
                $display("FAIL directed_frac_y%0d: got %0d, expected %0d", c, $signed(df), model_y(c, FRAC_B));
            end
        end
    endtask

    task automatic test_write_during_run();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        load_random(1'b1, 1'b1);
        bus_write(3'd0, 32'd1);
        // Three cycles of writes that must all be ignored while running.
        bus_write(3'd1, {16'd0, 16'h1234});
        bus_write(3'd2, {8'd1, 8'd2, 16'h4321});
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        checks++;
        if (busy !== N_MAC - 3 || st !== 32'd2 || stf !== 32'd2) begin
            errors++;
            $display("FAIL run_writes_latency: busy %0d status %h/%h, expected %0d and 2",
                     busy, st, stf, N_MAC - 3);
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                read_y(c, d, df);
                checks++;
                if (d !== 32'(model_y(c, 0)) || df !== 32'(model_y(c, FRAC_B))) begin
                    errors++;
                    $display("FAIL run_writes_y%0d_pass%0d: got %0d/%0d, expected %0d/%0d", c, pass,
                             $signed(d), $signed(df), model_y(c, 0), model_y(c, FRAC_B));
                end
            end
            if (pass == 0) begin
                bus_write(3'd0, 32'd1);
                run_measure(busy, st, stf);
                checks++;
                if (busy !== N_MAC || st !== 32'd2) begin
                    errors++;
                    $display("FAIL rerun_latency: busy %0d status %h, expected %0d and 2", busy, st, N_MAC);
                end
            end
        end
    endtask

    task automatic test_rw_same();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        bus_write(3'd4, 32'd0);
        read = 1'b1; write = 1'b1; addr = 32'd4; data_in = 32'd1;
        @(negedge clk);
        read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
        checks++;
        if (dout !== 32'(model_y(0, 0))) begin
            errors++;
            $display("FAIL rw_same_sel: got %0d, expected pre-write y0 %0d", $signed(dout), model_y(0, 0));
        end
        bus_read(3'd4, d, df);
        checks++;
        if (d !== 32'(model_y(1, 0))) begin
            errors++;
            $display("FAIL rw_same_sel_after: got %0d, expected y1 %0d", $signed(d), model_y(1, 0));
        end
        // Start from DONE while reading status: read sees done, then run restarts.
        read = 1'b1; write = 1'b1; addr = 32'd0; data_in = 32'd1;
        @(negedge clk);
        read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
        checks++;
        if (dout !== 32'd2) begin
            errors++;
            $display("FAIL rw_same_status: got %h, expected 2", dout);
        end
        run_measure(busy, st, stf);
        checks++;
        if (busy !== N_MAC || st !== 32'd2) begin
            errors++;
            $display("FAIL restart_from_done: busy %0d status %h, expected %0d and 2", busy, st, N_MAC);
        end
    endtask

    task automatic test_overflow();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        set_x(0, 200);
        set_x(1, 200);
        for (int r = 0; r < IN_DIM; r++)
            for (int c = 0; c < OUT_DIM; c++) set_w(r, c, 200);
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        read_y(0, d, df);
        checks++;
        if (d !== 32'(OVF_EXP)) begin
            errors++;
            $display("FAIL overflow_y0: got %0d, expected %0d", $signed(d), OVF_EXP);
        end
        checks++;
        if (df !== 32'd20000) begin
            errors++;
            $display("FAIL overflow_frac_y0: got %0d, expected 20000", $signed(df));
        end
        read_y(3, d, df);
        checks++;
        if (d !== 32'(model_y(3, 0))) begin
            errors++;
            $display("FAIL overflow_y3: got %0d, expected %0d", $signed(d), model_y(3, 0));
        end
    endtask

    task automatic test_out_of_range();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        set_x(2, 7);
        set_x(256, 9);
        set_w(2, 0, 11);
        set_w(0, 4, 13);
        set_w(2, 4, 15);
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        for (int c = 0; c < OUT_DIM; c++) begin
            read_y(c, d, df);
            checks++;
            if (d !== 32'(model_y(c, 0))) begin
                errors++;
                $display("FAIL oor_y%0d: got %0d, expected %0d", c, $signed(d), model_y(c, 0));
            end
        end
        read_y(7, d, df);
        checks++;
        if (d !== 32'd0 || df !== 32'd0) begin
            errors++;
            $display("FAIL oor_sel7: got %h/%h, expected 0", d, df);
        end
        bus_read(3'd5, d, df);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL oor_addr5: got %h, expected 0", d);
        end
    endtask

    task automatic test_reset_mid_run();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        load_random(1'b1, 1'b1);
        bus_write(3'd0, 32'd1);
        bus_read(3'd0, d, df);
        bus_read(3'd0, d, df);
        // Reset with a coincident read and vector write; reset must win.
        rst = 1'b1; read = 1'b1; write = 1'b1; addr = 32'd1; data_in = {16'd0, 16'h0055};
        @(negedge clk);
        rst = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
        model_clear();
        checks++;
        if (dout !== 32'd0 || dout_f !== 32'd0) begin
            errors++;
            $display("FAIL midrun_data_out: got %h/%h, expected 0", dout, dout_f);
        end
        bus_read(3'd0, d, df);
        checks++;
        if (d !== 32'd0 || df !== 32'd0) begin
            errors++;
            $display("FAIL midrun_status: got %h/%h, expected 0", d, df);
        end
        repeat (12) @(negedge clk);
        for (int c = 0; c < OUT_DIM; c++) begin
            read_y(c, d, df);
            checks++;
            if (d !== 32'd0 || df !== 32'd0) begin
                errors++;
                $display("FAIL midrun_y%0d: got %h/%h, expected 0", c, d, df);
            end
        end
        // Only x reloaded: W must have been cleared, so all results are zero.
        for (int step = 0; step < 2; step++) begin
            if (step == 0) load_random(1'b1, 1'b0);
            else load_random(1'b0, 1'b1);
            bus_write(3'd0, 32'd1);
            run_measure(busy, st, stf);
            checks++;
            if (busy !== N_MAC || st !== 32'd2) begin
                errors++;
                $display("FAIL post_reset_run%0d: busy %0d status %h, expected %0d and 2", step, busy, st, N_MAC);
            end
            for (int c = 0; c < OUT_DIM; c++) begin
                read_y(c, d, df);
                checks++;
                if (d !== 32'(model_y(c, 0)) || df !== 32'(model_y(c, FRAC_B))) begin
                    errors++;
                    $display("FAIL post_reset_y%0d_step%0d: got %0d/%0d, expected %0d/%0d", c, step,
                             $signed(d), $signed(df), model_y(c, 0), model_y(c, FRAC_B));
                end
            end
        end
    endtask

    task automatic test_frac();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        set_x(0, 4);
        set_x(1, 0);
        set_w(0, 0, 5);
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        read_y(0, d, df);
        checks++;
        if (df !== 32'd5 || d !== 32'd20) begin
            errors++;
            $display("FAIL frac_pos_y0: got %0d/%0d, expected 20/5", $signed(d), $signed(df));
        end
        set_x(0, -1);
        set_w(0, 0, 1);
        bus_write(3'd0, 32'd1);
        run_measure(busy, st, stf);
        read_y(0, d, df);
        checks++;
        if (df !== 32'hFFFF_FFFF || d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL frac_neg_y0: got %0d/%0d, expected -1/-1", $signed(d), $signed(df));
        end
    endtask

    task automatic test_random();
        int          busy;
        logic [31:0] st;
        logic [31:0] stf;
        logic [31:0] d;
        logic [31:0] df;
        for (int it = 0; it < 5; it++) begin
            load_random(1'b1, 1'b1);
            bus_write(3'd0, 32'd1);
            run_measure(busy, st, stf);
            checks++;
            if (busy !== N_MAC || st !== 32'd2 || stf !== 32'd2) begin
                errors++;
                $display("FAIL random%0d_latency: busy %0d status %h/%h, expected %0d and 2",
                         it, busy, st, stf, N_MAC);
            end
            for (int c = 0; c < OUT_DIM; c++) begin
                read_y(c, d, df);
                checks++;
                if (d !== 32'(model_y(c, 0)) || df !== 32'(model_y(c, FRAC_B))) begin
                    errors++;
                    $display("FAIL random%0d_y%0d: got %0d/%0d, expected %0d/%0d", it, c,
                             $signed(d), $signed(df), model_y(c, 0), model_y(c, FRAC_B));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_write_during_run();
        test_rw_same();
        test_overflow();
        test_out_of_range();
        test_reset_mid_run();
        test_frac();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
